// File: rtl/countdown_ctrl.sv
// Command sequencer for a WIDTH-bit down counter: loads N via latch/in, then
// issues a dec every P+1 cycles until zero, pulses done, optionally reloads.
module countdown_ctrl #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_count,
  input  logic [PW-1:0]    cmd_period,
  input  logic             cmd_reload,
  input  logic             abort,
  output logic             latch,
  output logic [WIDTH-1:0] in,
  output logic             dec,
  input  logic             zero,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg;
  logic [PW-1:0]    period_reg;
  logic [PW-1:0]    presc_reg;
  logic             reload_reg;
  logic             accept;

  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    dec        = 1'b0;
    done       = 1'b0;
    cmd_ready  = (state_reg == IDLE) && !abort;
    accept     = cmd_valid && cmd_ready;
    case (state_reg)
      IDLE: if (accept) state_next = LOAD;
      LOAD: begin
        latch      = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        // zero wins over a pending dec so the counter never wraps below 0
        if (zero) state_next = DONE;
        else      dec = (presc_reg == period_reg);
      end
      DONE: begin
        done       = 1'b1;
        state_next = reload_reg ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      latch      = 1'b0;
      dec        = 1'b0;
      done       = 1'b0;
    end
  end

  assign busy = (state_reg != IDLE);
  assign in   = count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      period_reg <= '0;
      presc_reg  <= '0;
      reload_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        count_reg  <= cmd_count;
        period_reg <= cmd_period;
        reload_reg <= cmd_reload;
      end else if (abort) begin
        reload_reg <= 1'b0;
      end
      if (state_reg == LOAD)
        presc_reg <= '0;
      else if (state_reg == RUN && !zero)
        presc_reg <= (presc_reg == period_reg) ? '0 : presc_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Random and directed commands against an arithmetic schedule model plus a
// behavioural 4-bit down counter driving zero.
module tb_countdown_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_count = '0;
  logic [3:0] cmd_period = '0;
  logic       cmd_reload = 1'b0;
  logic       abort = 1'b0;
  logic       latch, dec, done, busy, zero;
  logic [3:0] in;
  logic [3:0] cnt = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  countdown_ctrl #(.WIDTH(4), .PW(4)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_period(cmd_period), .cmd_reload(cmd_reload),
    .abort(abort), .latch(latch), .in(in), .dec(dec), .zero(zero),
    .done(done), .busy(busy)
  );

  // The down counter being controlled
  assign zero = (cnt == 4'd0);
  always @(posedge clock) begin
    if (latch)    cnt <= in;
    else if (dec) cnt <= cnt - 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Entered just after a rising edge. Cycle 0 is the acceptance cycle; each
  // command occupies L = N(P+1)+3 cycles: latch, N(P+1) run cycles, zero, done.
  task automatic run_cmd(input int n, input int p, input bit rl, input int ncyc,
                         input int abort_at, input bit hold);
    int L, r, ndec, ndone, nlatch;
    bit idle, el, ed, edn;
    L = n * (p + 1) + 3;
    ndec = 0; ndone = 0; nlatch = 0;
    cmd_valid = 1'b1; cmd_count = 4'(n); cmd_period = 4'(p); cmd_reload = rl;
    @(negedge clock);
    check("accept_ready", cmd_ready, 1);
    @(posedge clock); #1;
    cmd_valid = hold;
    for (int c = 1; c <= ncyc; c++) begin
      abort = (c == abort_at);
      if (hold) begin
        cmd_count = 4'($urandom_range(0, 15));
        cmd_period = 4'($urandom_range(0, 15));
      end
      @(negedge clock);
      idle = (abort_at > 0 && c > abort_at) || (!rl && c > L);
      r = (c - 1) % L;
      el = !idle && (r == 0);
      ed = !idle && r >= 1 && r <= n * (p + 1) && (r % (p + 1)) == 0;
      edn = !idle && (r == L - 1);
      if (c == abort_at) begin el = 0; ed = 0; edn = 0; end
      check("latch", latch, el);
      check("dec", dec, ed);
      check("done", done, edn);
      check("busy", busy, !idle);
      check("ready", cmd_ready, idle && !abort);
      check("in", in, n);
      if (edn) check("cnt_at_done", cnt, 0);
      ndec += dec; ndone += done; nlatch += latch;
      @(posedge clock); #1;
    end
    abort = 1'b0;
    $display("cmd N=%0d P=%0d reload=%0d abort_at=%0d: latch=%0d dec=%0d done=%0d over %0d cycles",
             n, p, rl, abort_at, nlatch, ndec, ndone, ncyc);
  endtask

  initial begin
    int n, p, L, ab;
    bit rl;
    #1;
    check("rst_busy", busy, 0);
    check("rst_latch", latch, 0);
    check("rst_in", in, 0);
    check("rst_ready", cmd_ready, 1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Basic run, N=0, back-to-back P=0
    run_cmd(3, 1, 0, 10, 0, 0);
    run_cmd(0, 5, 0, 4, 0, 0);
    run_cmd(15, 0, 0, 19, 0, 0);

    // Reload, then abort during the third pass
    run_cmd(2, 0, 1, 14, 12, 0);

    // Async reset mid-run
    run_cmd(5, 3, 0, 4, 0, 0);
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_latch", latch, 0);
    check("arst_dec", dec, 0);
    check("arst_done", done, 0);
    check("arst_in", in, 0);
    #2 reset = 1'b0;
    @(negedge clock);
    check("arst_ready", cmd_ready, 1);
    @(posedge clock); #1;
    run_cmd(2, 0, 0, 6, 0, 0);

    // cmd_valid held while busy, then abort with valid in IDLE
    run_cmd(4, 1, 0, 11, 0, 1);
    abort = 1'b1;
    @(negedge clock);
    check("abort_ready", cmd_ready, 0);
    check("abort_busy", busy, 0);
    @(posedge clock); #1;
    abort = 1'b0; cmd_valid = 1'b0;
    @(negedge clock);
    check("abort_noaccept_busy", busy, 0);
    check("abort_noaccept_latch", latch, 0);
    @(posedge clock); #1;

    // Randomized commands
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(0, 15);
      p = $urandom_range(0, 15);
      rl = 1'($urandom_range(0, 1));
      L = n * (p + 1) + 3;
      if (rl) begin
        ab = $urandom_range(1, 2 * L + 2);
        run_cmd(n, p, 1, ab + 2, ab, 0);
      end else begin
        run_cmd(n, p, 0, L + 1, 0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
